phase_sequencer: RTL and testbench

Central controller for the five-phase SIMPLE datapath. It derives the phase clocks clockp1..clockp5 from the single system clock and runs them in strict rotation, one instruction per rotation. Run, stop and single-step control come from the board. The halt flag from the decode stage is honoured at an instruction boundary. It also reports run status and an executed-instruction count.

---
 rtl/simple_pkg.sv | 15 +
 rtl/phase_timer.sv | 64 ++++++
 rtl/phase_sequencer.sv | 96 +++++++++
 tb/tb_phase_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared types and constants for the five-phase SIMPLE datapath controller.
package simple_pkg;

   typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

   localparam logic [2:0] P_NONE = 3'd0;
   localparam logic [2:0] P1     = 3'd1;
   localparam logic [2:0] P2     = 3'd2;
   localparam logic [2:0] P3     = 3'd3;
   localparam logic [2:0] P4     = 3'd4;
   localparam logic [2:0] P5     = 3'd5;

   localparam int unsigned NUM_PHASES = 5;

endpackage

// File: rtl/phase_timer.sv
// Phase window timer: sub-cycle counter plus phase index, exposing next-cycle
// phase-high vector and phase so the caller can register them without lag.
module phase_timer
   import simple_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  wrap,
   output logic                  boundary,
   output logic [NUM_PHASES-1:0] nxt_hi,
   output logic [2:0]            nxt_phase
);

   localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

   logic [CW-1:0] cnt, n_cnt;
   logic [2:0]    idx, n_idx;

   assign boundary = (idx == P5) && (cnt == CW'(PHASE_CYCLES - 1));

   always_comb begin
      n_cnt = cnt;
      n_idx = idx;
      if (load) begin
         n_idx = P1;
         n_cnt = '0;
      end else if (idx != P_NONE) begin
         if (cnt == CW'(PHASE_CYCLES - 1)) begin
            n_cnt = '0;
            case (idx)
               P1:      n_idx = P2;
               P2:      n_idx = P3;
               P3:      n_idx = P4;
               P4:      n_idx = P5;
               P5:      n_idx = wrap ? P1 : P_NONE;
               default: n_idx = P_NONE;
            endcase
         end else begin
            n_cnt = cnt + 1'b1;
         end
      end
   end

   always_comb begin
      nxt_hi    = '0;
      nxt_phase = n_idx;
      if ((n_idx != P_NONE) && (n_cnt == '0))
         nxt_hi = NUM_PHASES'(1) << (n_idx - 3'd1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         idx <= P_NONE;
      end else begin
         cnt <= n_cnt;
         idx <= n_idx;
      end
   end

endmodule

// File: rtl/phase_sequencer.sv
// Run/stop/step/halt controller driving the five phase clocks in rotation,
// with pending stop/halt honoured only at the end of the phase-5 window.
module phase_sequencer
   import simple_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = 2,
   parameter int unsigned COUNT_W      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               step,
   input  logic               haltin,
   output logic               clockp1,
   output logic               clockp2,
   output logic               clockp3,
   output logic               clockp4,
   output logic               clockp5,
   output logic [2:0]         phase,
   output logic               running,
   output logic               halted,
   output logic [COUNT_W-1:0] instcount
);

   state_t                  state, nstate;
   logic                    halt_pending, stop_pending;
   logic                    halt_now, stop_now;
   logic                    load, wrap, boundary;
   logic [NUM_PHASES-1:0]   nxt_hi;
   logic [2:0]              nxt_phase;

   phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .wrap      (wrap),
      .boundary  (boundary),
      .nxt_hi    (nxt_hi),
      .nxt_phase (nxt_phase)
   );

   // haltin only counts once decode has latched it (phases 3..5); a stop
   // arriving in the boundary cycle itself still applies to that boundary.
   always_comb begin
      halt_now = halt_pending | (haltin & ((phase == P3) | (phase == P4) | (phase == P5)));
      stop_now = stop_pending | (stop & (state == RUN));
      nstate   = state;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               nstate = RUN;
               load   = 1'b1;
            end else if (step && !start) begin
               nstate = STEP;
               load   = 1'b1;
            end
         end
         RUN, STEP: begin
            if (boundary) begin
               if (halt_now)
                  nstate = HALTED;
               else if (stop_now || (state == STEP))
                  nstate = IDLE;
            end
         end
         default: nstate = state;
      endcase
      wrap = (nstate == RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         halt_pending <= 1'b0;
         stop_pending <= 1'b0;
         {clockp5, clockp4, clockp3, clockp2, clockp1} <= '0;
         phase        <= P_NONE;
         running      <= 1'b0;
         halted       <= 1'b0;
         instcount    <= '0;
      end else begin
         state        <= nstate;
         halt_pending <= halt_now;
         stop_pending <= stop_now && (nstate != IDLE);
         {clockp5, clockp4, clockp3, clockp2, clockp1} <= nxt_hi;
         phase        <= nxt_phase;
         running      <= (nstate == RUN) || (nstate == STEP);
         halted       <= (nstate == HALTED);
         if (boundary)
            instcount <= instcount + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed scenarios plus random control pulses,
// checked every cycle against a rotation-position reference model.
module tb_phase_sequencer;

   localparam int PC  = 2;
   localparam int CW  = 4;
   localparam int ROT = 5 * PC;

   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0, haltin = 1'b0;
   logic          clockp1, clockp2, clockp3, clockp4, clockp5;
   logic [2:0]    phase;
   logic          running, halted;
   logic [CW-1:0] instcount;

   int n_assert = 0;
   int n_fail   = 0;

   // model: mode, position within a rotation (-1 = none), pending flags, count
   int m_mode = M_IDLE;
   int m_pos  = -1;
   int m_cnt  = 0;
   bit m_hp   = 0;
   bit m_sp   = 0;
   bit hlev   = 0;

   phase_sequencer #(.PHASE_CYCLES(PC), .COUNT_W(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .step      (step),
      .haltin    (haltin),
      .clockp1   (clockp1),
      .clockp2   (clockp2),
      .clockp3   (clockp3),
      .clockp4   (clockp4),
      .clockp5   (clockp5),
      .phase     (phase),
      .running   (running),
      .halted    (halted),
      .instcount (instcount)
   );

   always #5 clock = ~clock;

   function automatic int model_phase();
      return (m_pos < 0) ? 0 : (m_pos / PC) + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit s, input bit p, input bit st, input bit h, input bit r);
      if (r) begin
         m_mode = M_IDLE; m_pos = -1; m_cnt = 0; m_hp = 0; m_sp = 0;
         return;
      end
      if (h && model_phase() >= 3) m_hp = 1;
      if (p && m_mode == M_RUN) m_sp = 1;
      case (m_mode)
         M_IDLE: begin
            if (s && !p) begin m_mode = M_RUN; m_pos = 0; end
            else if (st && !s) begin m_mode = M_STEP; m_pos = 0; end
         end
         M_RUN, M_STEP: begin
            if (m_pos == ROT - 1) begin
               m_cnt = (m_cnt + 1) % (1 << CW);
               if (m_hp) begin m_mode = M_HALT; m_pos = -1; end
               else if (m_sp || m_mode == M_STEP) begin m_mode = M_IDLE; m_pos = -1; m_sp = 0; end
               else m_pos = 0;
            end else begin
               m_pos++;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_outputs();
      logic [4:0] e;
      e = '0;
      if (m_pos >= 0 && (m_pos % PC) == 0) e[m_pos / PC] = 1'b1;
      check("clockp", {27'd0, clockp5, clockp4, clockp3, clockp2, clockp1}, {27'd0, e});
      check("phase", {29'd0, phase}, model_phase());
      check("running", {31'd0, running}, (m_mode == M_RUN || m_mode == M_STEP) ? 1 : 0);
      check("halted", {31'd0, halted}, (m_mode == M_HALT) ? 1 : 0);
      check("instcount", {28'd0, instcount}, m_cnt);
   endtask

   task automatic tick(input bit s, input bit p, input bit st, input bit r);
      start = s; stop = p; step = st; reset = r; haltin = hlev;
      @(posedge clock);
      model_edge(s, p, st, hlev, r);
      #1;
      check_outputs();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
   endtask

   task automatic wait_for(input int ph, input int cnt, input int limit);
      int n;
      n = 0;
      while (!(model_phase() == ph && m_cnt == cnt) && n < limit) begin
         tick(0, 0, 0, 0);
         n++;
      end
      check("wait_bound", (n < limit) ? 1 : 0, 1);
   endtask

   initial begin
      // reset state
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      check("rst_count", {28'd0, instcount}, 0);

      // first-rotation timing after start at edge 0
      tick(1, 0, 0, 0);
      check("c1_p1", {31'd0, clockp1}, 1);
      idle_n(2);
      check("c3_p2", {31'd0, clockp2}, 1);
      idle_n(6);
      check("c9_p5", {31'd0, clockp5}, 1);
      idle_n(1);
      check("c10_cnt", {28'd0, instcount}, 0);
      idle_n(1);
      check("c11_p1", {31'd0, clockp1}, 1);
      check("c11_cnt", {28'd0, instcount}, 1);

      // stop during p2 of instruction 3
      wait_for(2, 2, 100);
      tick(0, 1, 0, 0);
      idle_n(30);
      check("stop_cnt", {28'd0, instcount}, 3);
      check("stop_run", {31'd0, running}, 0);

      // single step from IDLE
      tick(0, 0, 0, 1);
      tick(0, 0, 1, 0);
      idle_n(30);
      check("step_cnt", {28'd0, instcount}, 1);
      check("step_run", {31'd0, running}, 0);

      // halt raised during p2 of instruction 2, then ignored controls
      tick(0, 0, 0, 1);
      tick(1, 0, 0, 0);
      wait_for(2, 1, 100);
      hlev = 1;
      idle_n(40);
      tick(1, 0, 0, 0);
      idle_n(3);
      tick(0, 0, 1, 0);
      idle_n(3);
      check("halt_flag", {31'd0, halted}, 1);
      check("halt_cnt", {28'd0, instcount}, 2);
      hlev = 0;

      // reset in the clockp3 high cycle, then restart
      tick(0, 0, 0, 1);
      tick(1, 0, 0, 0);
      wait_for(3, 0, 100);
      check("mid_p3", {31'd0, clockp3}, 1);
      tick(0, 0, 0, 1);
      check("mid_rst_phase", {29'd0, phase}, 0);
      tick(1, 0, 0, 0);
      check("re_p1", {31'd0, clockp1}, 1);
      idle_n(12);
      tick(0, 0, 0, 1);

      // start and stop together stay idle
      tick(1, 1, 0, 0);
      idle_n(3);
      check("ss_run", {31'd0, running}, 0);

      // 17 instructions wrap the 4-bit counter to 1
      tick(1, 0, 0, 0);
      idle_n(160);
      tick(0, 1, 0, 0);
      idle_n(15);
      check("wrap_cnt", {28'd0, instcount}, 1);
      check("wrap_run", {31'd0, running}, 0);

      // random control traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(39) == 0) hlev = ~hlev;
         tick($urandom_range(9) == 0, $urandom_range(11) == 0,
              $urandom_range(9) == 0, $urandom_range(79) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
